// File: rtl/axi_grid_link_buffer.sv
// rtl/axi_grid_link_buffer.sv - five-channel buffered grid link with per-channel FIFOs and flush

module axi_grid_link_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, resetn, flush};
        assign out_data    = in_data;
        assign out_valid   = in_valid;
        assign in_ready    = out_ready;
        assign count       = '0;
    end else begin : g_fifo
        localparam int unsigned PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

        logic [WIDTH-1:0] mem [DEPTH];
        logic [WIDTH-1:0] last_q;
        logic [PW-1:0]    wr_ptr;
        logic [PW-1:0]    rd_ptr;
        logic [PW-1:0]    wr_next;
        logic [PW-1:0]    rd_next;
        logic [CW-1:0]    count_q;
        logic             push;
        logic             pop;

        // Ready never looks at out_ready, so a full buffer cannot accept even while popping.
        assign in_ready  = (count_q != CW'(DEPTH)) && !flush && resetn;
        assign out_valid = (count_q != '0) && !flush;
        assign push      = in_valid && in_ready;
        assign pop       = out_valid && out_ready;
        assign count     = count_q;

        // Once drained, keep presenting the last flit handed downstream.
        assign out_data  = (count_q != '0) ? mem[rd_ptr] : last_q;

        assign wr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        assign rd_next = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);

        always_ff @(posedge clk) begin
            if (!resetn) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
                last_q  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= in_data;
                    wr_ptr      <= wr_next;
                end
                if (pop) begin
                    last_q <= mem[rd_ptr];
                    rd_ptr <= rd_next;
                end
                if (push && !pop) begin
                    count_q <= count_q + CW'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - CW'(1);
                end
            end
        end
    end

endmodule

module axi_grid_link_buffer #(
    parameter type grid_id_t      = logic [3:0],
    parameter type grid_aw_chan_t = logic [15:0],
    parameter type grid_w_chan_t  = logic [15:0],
    parameter type grid_b_chan_t  = logic [7:0],
    parameter type grid_ar_chan_t = logic [15:0],
    parameter type grid_r_chan_t  = logic [15:0],
    parameter int unsigned AW_DEPTH = 2,
    parameter int unsigned W_DEPTH  = 2,
    parameter int unsigned B_DEPTH  = 2,
    parameter int unsigned AR_DEPTH = 2,
    parameter int unsigned R_DEPTH  = 2,
    localparam int unsigned AW_CW = (AW_DEPTH == 0) ? 1 : $clog2(AW_DEPTH + 1),
    localparam int unsigned W_CW  = (W_DEPTH == 0) ? 1 : $clog2(W_DEPTH + 1),
    localparam int unsigned B_CW  = (B_DEPTH == 0) ? 1 : $clog2(B_DEPTH + 1),
    localparam int unsigned AR_CW = (AR_DEPTH == 0) ? 1 : $clog2(AR_DEPTH + 1),
    localparam int unsigned R_CW  = (R_DEPTH == 0) ? 1 : $clog2(R_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             flush_i,

    input  grid_id_t         awdid_i,
    input  grid_id_t         awsid_i,
    input  grid_aw_chan_t    awchan_i,
    input  logic             awvalid_i,
    output logic             awready_o,
    output grid_id_t         awdid_o,
    output grid_id_t         awsid_o,
    output grid_aw_chan_t    awchan_o,
    output logic             awvalid_o,
    input  logic             awready_i,
    output logic [AW_CW-1:0] awcount_o,

    input  grid_id_t         wdid_i,
    input  grid_id_t         wsid_i,
    input  grid_w_chan_t     wchan_i,
    input  logic             wvalid_i,
    output logic             wready_o,
    output grid_id_t         wdid_o,
    output grid_id_t         wsid_o,
    output grid_w_chan_t     wchan_o,
    output logic             wvalid_o,
    input  logic             wready_i,
    output logic [W_CW-1:0]  wcount_o,

    input  grid_id_t         bdid_i,
    input  grid_id_t         bsid_i,
    input  grid_b_chan_t     bchan_i,
    input  logic             bvalid_i,
    output logic             bready_o,
    output grid_id_t         bdid_o,
    output grid_id_t         bsid_o,
    output grid_b_chan_t     bchan_o,
    output logic             bvalid_o,
    input  logic             bready_i,
    output logic [B_CW-1:0]  bcount_o,

    input  grid_id_t         ardid_i,
    input  grid_id_t         arsid_i,
    input  grid_ar_chan_t    archan_i,
    input  logic             arvalid_i,
    output logic             arready_o,
    output grid_id_t         ardid_o,
    output grid_id_t         arsid_o,
    output grid_ar_chan_t    archan_o,
    output logic             arvalid_o,
    input  logic             arready_i,
    output logic [AR_CW-1:0] arcount_o,

    input  grid_id_t         rdid_i,
    input  grid_id_t         rsid_i,
    input  grid_r_chan_t     rchan_i,
    input  logic             rvalid_i,
    output logic             rready_o,
    output grid_id_t         rdid_o,
    output grid_id_t         rsid_o,
    output grid_r_chan_t     rchan_o,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [R_CW-1:0]  rcount_o
);

    localparam int unsigned IDW  = $bits(grid_id_t);
    localparam int unsigned AW_W = 2 * IDW + $bits(grid_aw_chan_t);
    localparam int unsigned W_W  = 2 * IDW + $bits(grid_w_chan_t);
    localparam int unsigned B_W  = 2 * IDW + $bits(grid_b_chan_t);
    localparam int unsigned AR_W = 2 * IDW + $bits(grid_ar_chan_t);
    localparam int unsigned R_W  = 2 * IDW + $bits(grid_r_chan_t);

    logic [AW_W-1:0] aw_out;
    logic [W_W-1:0]  w_out;
    logic [B_W-1:0]  b_out;
    logic [AR_W-1:0] ar_out;
    logic [R_W-1:0]  r_out;

    assign {awdid_o, awsid_o, awchan_o} = aw_out;
    assign {wdid_o, wsid_o, wchan_o}    = w_out;
    assign {bdid_o, bsid_o, bchan_o}    = b_out;
    assign {ardid_o, arsid_o, archan_o} = ar_out;
    assign {rdid_o, rsid_o, rchan_o}    = r_out;

    axi_grid_link_fifo #(.DEPTH(AW_DEPTH), .WIDTH(AW_W)) i_aw_fifo (
        .clk       (clk_i),
        .resetn    (arst_ni),
        .flush     (flush_i),
        .in_data   ({awdid_i, awsid_i, awchan_i}),
        .in_valid  (awvalid_i),
        .in_ready  (awready_o),
        .out_data  (aw_out),
        .out_valid (awvalid_o),
        .out_ready (awready_i),
        .count     (awcount_o)
    );

    axi_grid_link_fifo #(.DEPTH(W_DEPTH), .WIDTH(W_W)) i_w_fifo (
        .clk       (clk_i),
        .resetn    (arst_ni),
        .flush     (flush_i),
        .in_data   ({wdid_i, wsid_i, wchan_i}),
        .in_valid  (wvalid_i),
        .in_ready  (wready_o),
        .out_data  (w_out),
        .out_valid (wvalid_o),
        .out_ready (wready_i),
        .count     (wcount_o)
    );

    axi_grid_link_fifo #(.DEPTH(B_DEPTH), .WIDTH(B_W)) i_b_fifo (
        .clk       (clk_i),
        .resetn    (arst_ni),
        .flush     (flush_i),
        .in_data   ({bdid_i, bsid_i, bchan_i}),
        .in_valid  (bvalid_i),
        .in_ready  (bready_o),
        .out_data  (b_out),
        .out_valid (bvalid_o),
        .out_ready (bready_i),
        .count     (bcount_o)
    );

    axi_grid_link_fifo #(.DEPTH(AR_DEPTH), .WIDTH(AR_W)) i_ar_fifo (
        .clk       (clk_i),
        .resetn    (arst_ni),
        .flush     (flush_i),
        .in_data   ({ardid_i, arsid_i, archan_i}),
        .in_valid  (arvalid_i),
        .in_ready  (arready_o),
        .out_data  (ar_out),
        .out_valid (arvalid_o),
        .out_ready (arready_i),
        .count     (arcount_o)
    );

    axi_grid_link_fifo #(.DEPTH(R_DEPTH), .WIDTH(R_W)) i_r_fifo (
        .clk       (clk_i),
        .resetn    (arst_ni),
        .flush     (flush_i),
        .in_data   ({rdid_i, rsid_i, rchan_i}),
        .in_valid  (rvalid_i),
        .in_ready  (rready_o),
        .out_data  (r_out),
        .out_valid (rvalid_o),
        .out_ready (rready_i),
        .count     (rcount_o)
    );

endmodule

// File: tb/tb_axi_grid_link_buffer.sv
// tb/tb_axi_grid_link_buffer.sv - directed self-checking bench for axi_grid_link_buffer

module tb_axi_grid_link_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst_n, flush;
    int   tests = 0;
    int   fails = 0;

    // Shared upstream/downstream stimulus for both instances.
    logic [3:0]  aw_did, aw_sid, w_did, w_sid, b_did, b_sid, ar_did, ar_sid, r_did, r_sid;
    logic [15:0] aw_chan, w_chan, ar_chan, r_chan;
    logic [7:0]  b_chan;
    logic        aw_valid, w_valid, b_valid, ar_valid, r_valid;
    logic        aw_ready, w_ready, b_ready, ar_ready, r_ready;

    // Buffered instance outputs.
    logic [3:0]  aw_did_q, aw_sid_q, w_did_q, w_sid_q, b_did_q, b_sid_q, ar_did_q, ar_sid_q, r_did_q, r_sid_q;
    logic [15:0] aw_chan_q, w_chan_q, ar_chan_q, r_chan_q;
    logic [7:0]  b_chan_q;
    logic        aw_valid_q, w_valid_q, b_valid_q, ar_valid_q, r_valid_q;
    logic        aw_ready_up, w_ready_up, b_ready_up, ar_ready_up, r_ready_up;
    logic [1:0]  aw_count, w_count, b_count;
    logic [2:0]  ar_count;
    logic [0:0]  r_count;

    // Bypass instance outputs.
    logic [3:0]  by_aw_did_q, by_aw_sid_q, by_w_did_q, by_w_sid_q, by_b_did_q, by_b_sid_q;
    logic [3:0]  by_ar_did_q, by_ar_sid_q, by_r_did_q, by_r_sid_q;
    logic [15:0] by_aw_chan_q, by_w_chan_q, by_ar_chan_q, by_r_chan_q;
    logic [7:0]  by_b_chan_q;
    logic        by_aw_valid_q, by_w_valid_q, by_b_valid_q, by_ar_valid_q, by_r_valid_q;
    logic        by_aw_ready_up, by_w_ready_up, by_b_ready_up, by_ar_ready_up, by_r_ready_up;
    logic [0:0]  by_aw_count, by_w_count, by_b_count, by_ar_count, by_r_count;

    axi_grid_link_buffer #(
        .AW_DEPTH(2), .W_DEPTH(3), .B_DEPTH(3), .AR_DEPTH(4), .R_DEPTH(1)
    ) dut (
        .clk_i(clk), .arst_ni(arst_n), .flush_i(flush),
        .awdid_i(aw_did), .awsid_i(aw_sid), .awchan_i(aw_chan), .awvalid_i(aw_valid), .awready_o(aw_ready_up),
        .awdid_o(aw_did_q), .awsid_o(aw_sid_q), .awchan_o(aw_chan_q), .awvalid_o(aw_valid_q), .awready_i(aw_ready),
        .awcount_o(aw_count),
        .wdid_i(w_did), .wsid_i(w_sid), .wchan_i(w_chan), .wvalid_i(w_valid), .wready_o(w_ready_up),
        .wdid_o(w_did_q), .wsid_o(w_sid_q), .wchan_o(w_chan_q), .wvalid_o(w_valid_q), .wready_i(w_ready),
        .wcount_o(w_count),
        .bdid_i(b_did), .bsid_i(b_sid), .bchan_i(b_chan), .bvalid_i(b_valid), .bready_o(b_ready_up),
        .bdid_o(b_did_q), .bsid_o(b_sid_q), .bchan_o(b_chan_q), .bvalid_o(b_valid_q), .bready_i(b_ready),
        .bcount_o(b_count),
        .ardid_i(ar_did), .arsid_i(ar_sid), .archan_i(ar_chan), .arvalid_i(ar_valid), .arready_o(ar_ready_up),
        .ardid_o(ar_did_q), .arsid_o(ar_sid_q), .archan_o(ar_chan_q), .arvalid_o(ar_valid_q), .arready_i(ar_ready),
        .arcount_o(ar_count),
        .rdid_i(r_did), .rsid_i(r_sid), .rchan_i(r_chan), .rvalid_i(r_valid), .rready_o(r_ready_up),
        .rdid_o(r_did_q), .rsid_o(r_sid_q), .rchan_o(r_chan_q), .rvalid_o(r_valid_q), .rready_i(r_ready),
        .rcount_o(r_count)
    );

    axi_grid_link_buffer #(
        .AW_DEPTH(0), .W_DEPTH(0), .B_DEPTH(0), .AR_DEPTH(0), .R_DEPTH(0)
    ) dut_bypass (
        .clk_i(clk), .arst_ni(arst_n), .flush_i(flush),
        .awdid_i(aw_did), .awsid_i(aw_sid), .awchan_i(aw_chan), .awvalid_i(aw_valid), .awready_o(by_aw_ready_up),
        .awdid_o(by_aw_did_q), .awsid_o(by_aw_sid_q), .awchan_o(by_aw_chan_q), .awvalid_o(by_aw_valid_q),
        .awready_i(aw_ready), .awcount_o(by_aw_count),
        .wdid_i(w_did), .wsid_i(w_sid), .wchan_i(w_chan), .wvalid_i(w_valid), .wready_o(by_w_ready_up),
        .wdid_o(by_w_did_q), .wsid_o(by_w_sid_q), .wchan_o(by_w_chan_q), .wvalid_o(by_w_valid_q),
        .wready_i(w_ready), .wcount_o(by_w_count),
        .bdid_i(b_did), .bsid_i(b_sid), .bchan_i(b_chan), .bvalid_i(b_valid), .bready_o(by_b_ready_up),
        .bdid_o(by_b_did_q), .bsid_o(by_b_sid_q), .bchan_o(by_b_chan_q), .bvalid_o(by_b_valid_q),
        .bready_i(b_ready), .bcount_o(by_b_count),
        .ardid_i(ar_did), .arsid_i(ar_sid), .archan_i(ar_chan), .arvalid_i(ar_valid), .arready_o(by_ar_ready_up),
        .ardid_o(by_ar_did_q), .arsid_o(by_ar_sid_q), .archan_o(by_ar_chan_q), .arvalid_o(by_ar_valid_q),
        .arready_i(ar_ready), .arcount_o(by_ar_count),
        .rdid_i(r_did), .rsid_i(r_sid), .rchan_i(r_chan), .rvalid_i(r_valid), .rready_o(by_r_ready_up),
        .rdid_o(by_r_did_q), .rsid_o(by_r_sid_q), .rchan_o(by_r_chan_q), .rvalid_o(by_r_valid_q),
        .rready_i(r_ready), .rcount_o(by_r_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] act;
        arst_n = 1'b0;
        tick();
        tick();
        tests++;
        act = {27'd0, aw_ready_up, w_ready_up, b_ready_up, ar_ready_up, r_ready_up};
        if (act !== 32'd0) begin fails++; $display("FAIL reset_ready got %h exp %h", act, 32'd0); end
        tests++;
        act = {17'd0, aw_valid_q, w_valid_q, b_valid_q, ar_valid_q, r_valid_q, aw_count, w_count, b_count, ar_count, r_count};
        if (act !== 32'd0) begin fails++; $display("FAIL reset_valid_count got %h exp %h", act, 32'd0); end
        tests++;
        if ({aw_did_q, aw_sid_q, aw_chan_q, b_did_q, b_chan_q} !== 44'd0) begin
            fails++; $display("FAIL reset_data got %h exp 0", {aw_did_q, aw_sid_q, aw_chan_q, b_did_q, b_chan_q});
        end
        arst_n = 1'b1;
        #1;
        tests++;
        act = {27'd0, aw_ready_up, w_ready_up, b_ready_up, ar_ready_up, r_ready_up};
        if (act !== 32'h1f) begin fails++; $display("FAIL release_ready got %h exp %h", act, 32'h1f); end
        tick();
    endtask

    task automatic test_aw_stream();
        logic [26:0] act, exp;
        aw_ready = 1'b1; aw_did = 4'd3; aw_sid = 4'd1;
        for (int k = 0; k <= 8; k++) begin
            aw_valid = (k < 8);
            aw_chan  = 16'(32'h10 + k);
            #1;
            if (k >= 1) begin
                tests++;
                act = {aw_valid_q, aw_did_q, aw_sid_q, aw_chan_q, aw_count};
                exp = {1'b1, 4'd3, 4'd1, 16'(32'h10 + k - 1), 2'd1};
                if (act !== exp) begin fails++; $display("FAIL aw_stream[%0d] got %h exp %h", k, act, exp); end
            end
            tick();
        end
        aw_valid = 1'b0;
        #1;
        tests++;
        if ({aw_valid_q, aw_chan_q, aw_count} !== {1'b0, 16'h0017, 2'd0}) begin
            fails++; $display("FAIL aw_empty_hold got %h exp %h", {aw_valid_q, aw_chan_q, aw_count}, {1'b0, 16'h0017, 2'd0});
        end
        aw_ready = 1'b0;
        tick();
    endtask

    task automatic test_w_backpressure();
        int sent, got, acc_cycle;
        w_ready = 1'b0; w_did = 4'd2; w_sid = 4'd5;
        for (int k = 0; k < 3; k++) begin
            w_valid = 1'b1;
            w_chan  = 16'(32'hA0 + k);
            #1;
            tests++;
            if (w_ready_up !== 1'b1) begin fails++; $display("FAIL w_fill_ready[%0d] got %b exp 1", k, w_ready_up); end
            tick();
        end
        w_chan = 16'hA3;
        #1;
        tests++;
        if ({w_ready_up, w_valid_q, w_chan_q, w_count} !== {1'b0, 1'b1, 16'hA0, 2'd3}) begin
            fails++; $display("FAIL w_full got %h exp %h", {w_ready_up, w_valid_q, w_chan_q, w_count}, {1'b0, 1'b1, 16'hA0, 2'd3});
        end
        tick();
        w_ready = 1'b1; sent = 3; got = 0; acc_cycle = -1;
        for (int c = 0; c < 8; c++) begin
            w_valid = (sent < 4);
            w_chan  = 16'(32'hA0 + sent);
            #1;
            if (w_valid_q && w_ready) begin
                tests++;
                if (w_chan_q !== 16'(32'hA0 + got)) begin
                    fails++; $display("FAIL w_order[%0d] got %h exp %h", got, w_chan_q, 16'(32'hA0 + got));
                end
                got++;
            end
            if (w_valid && w_ready_up) begin acc_cycle = c; sent++; end
            tick();
        end
        tests++;
        if (got !== 4 || acc_cycle !== 1) begin
            fails++; $display("FAIL w_drain got %0d/%0d exp 4/1", got, acc_cycle);
        end
        w_valid = 1'b0; w_ready = 1'b0;
    endtask

    task automatic test_r_depth1();
        int sent, got;
        logic odd;
        r_ready = 1'b1; r_did = 4'd1; r_sid = 4'd2; sent = 0; got = 0;
        for (int c = 0; c < 12; c++) begin
            r_valid = (sent < 6);
            r_chan  = 16'(32'h50 + sent);
            odd     = (c % 2) == 1;
            #1;
            tests++;
            if ({r_ready_up, r_valid_q, r_count} !== {~odd, odd, odd}) begin
                fails++; $display("FAIL r_alt[%0d] got %b exp %b", c, {r_ready_up, r_valid_q, r_count}, {~odd, odd, odd});
            end
            if (r_valid_q && r_ready) begin
                tests++;
                if (r_chan_q !== 16'(32'h50 + got)) begin
                    fails++; $display("FAIL r_order[%0d] got %h exp %h", got, r_chan_q, 16'(32'h50 + got));
                end
                got++;
            end
            if (r_valid && r_ready_up) sent++;
            tick();
        end
        tests++;
        if (got !== 6 || r_count !== 1'b0) begin
            fails++; $display("FAIL r_total got %0d count %0d exp 6 count 0", got, r_count);
        end
        r_valid = 1'b0; r_ready = 1'b0;
    endtask

    task automatic test_b_wrap();
        int          sent, got;
        logic [15:0] pat;
        logic        prev_stall;
        logic [7:0]  prev_chan;
        pat = 16'b1011_0010_1110_0101;
        sent = 0; got = 0; prev_stall = 1'b0; prev_chan = '0; b_sid = 4'hC;
        for (int c = 0; c < 80; c++) begin
            b_valid = (sent < 10);
            b_chan  = 8'(32'h30 + sent);
            b_did   = 4'(sent);
            b_ready = pat[c % 16];
            #1;
            if (prev_stall) begin
                tests++;
                if (!b_valid_q || b_chan_q !== prev_chan) begin
                    fails++; $display("FAIL b_stable[%0d] got %b/%h exp 1/%h", c, b_valid_q, b_chan_q, prev_chan);
                end
            end
            if (b_valid_q && b_ready) begin
                tests++;
                if ({b_did_q, b_sid_q, b_chan_q} !== {4'(got), 4'hC, 8'(32'h30 + got)}) begin
                    fails++; $display("FAIL b_order[%0d] got %h exp %h", got, {b_did_q, b_sid_q, b_chan_q}, {4'(got), 4'hC, 8'(32'h30 + got)});
                end
                got++;
            end
            prev_stall = b_valid_q && !b_ready;
            prev_chan  = b_chan_q;
            if (b_valid && b_ready_up) sent++;
            tick();
            if (got == 10) break;
        end
        tests++;
        if (got !== 10 || sent !== 10 || b_count !== 2'd0) begin
            fails++; $display("FAIL b_total got %0d sent %0d count %0d exp 10 10 0", got, sent, b_count);
        end
        b_valid = 1'b0; b_ready = 1'b0;
    endtask

    task automatic test_flush();
        ar_ready = 1'b0; ar_did = 4'd7; ar_sid = 4'd6;
        for (int k = 0; k < 3; k++) begin
            ar_valid = 1'b1;
            ar_chan  = 16'(32'hC0 + k);
            tick();
        end
        ar_valid = 1'b0;
        #1;
        tests++;
        if (ar_count !== 3'd3) begin fails++; $display("FAIL ar_prefill got %0d exp 3", ar_count); end
        flush = 1'b1; ar_valid = 1'b1; ar_chan = 16'hEE; ar_ready = 1'b1;
        #1;
        tests++;
        if ({ar_valid_q, ar_ready_up} !== 2'b00) begin
            fails++; $display("FAIL ar_flush_cycle got %b exp 00", {ar_valid_q, ar_ready_up});
        end
        tick();
        flush = 1'b0; ar_chan = 16'h77;
        #1;
        tests++;
        if ({ar_count, ar_valid_q, ar_ready_up} !== {3'd0, 1'b0, 1'b1}) begin
            fails++; $display("FAIL ar_after_flush got %b exp %b", {ar_count, ar_valid_q, ar_ready_up}, {3'd0, 1'b0, 1'b1});
        end
        tick();
        ar_valid = 1'b0;
        #1;
        tests++;
        if ({ar_valid_q, ar_chan_q, ar_count} !== {1'b1, 16'h77, 3'd1}) begin
            fails++; $display("FAIL ar_post_flush got %h exp %h", {ar_valid_q, ar_chan_q, ar_count}, {1'b1, 16'h77, 3'd1});
        end
        tick();
        ar_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        aw_ready = 1'b0; aw_did = 4'd9; aw_sid = 4'd4;
        for (int k = 0; k < 2; k++) begin
            aw_valid = 1'b1;
            aw_chan  = 16'(32'hD0 + k);
            tick();
        end
        aw_valid = 1'b0;
        #1;
        tests++;
        if (aw_count !== 2'd2) begin fails++; $display("FAIL rm_prefill got %0d exp 2", aw_count); end
        arst_n = 1'b0;
        #1;
        tests++;
        if (aw_ready_up !== 1'b0) begin fails++; $display("FAIL rm_ready_low got %b exp 0", aw_ready_up); end
        tick();
        arst_n = 1'b1;
        #1;
        tests++;
        if ({aw_count, aw_valid_q, aw_did_q, aw_sid_q, aw_chan_q, aw_ready_up} !== {2'd0, 1'b0, 24'd0, 1'b1}) begin
            fails++; $display("FAIL rm_cleared got %h exp %h", {aw_count, aw_valid_q, aw_did_q, aw_sid_q, aw_chan_q, aw_ready_up}, {2'd0, 1'b0, 24'd0, 1'b1});
        end
        aw_valid = 1'b1; aw_chan = 16'h99; aw_ready = 1'b1;
        tick();
        aw_valid = 1'b0;
        #1;
        tests++;
        if ({aw_valid_q, aw_did_q, aw_chan_q} !== {1'b1, 4'd9, 16'h99}) begin
            fails++; $display("FAIL rm_new_flit got %h exp %h", {aw_valid_q, aw_did_q, aw_chan_q}, {1'b1, 4'd9, 16'h99});
        end
        tick();
        aw_ready = 1'b0;
    endtask

    task automatic test_bypass();
        logic [25:0] act_aw, exp_aw;
        logic [15:0] act_rdy, exp_rdy;
        logic [31:0] act_dat, exp_dat;
        for (int v = 0; v < 4; v++) begin
            flush  = v[0];
            arst_n = (v != 2);
            aw_valid = v[1]; aw_ready = v[0] ^ v[1];
            aw_did = 4'(v + 5); aw_sid = 4'(v); aw_chan = 16'(32'h1234 * (v + 1));
            w_valid = v[0]; w_ready = ~v[0]; w_chan = 16'(32'hBEEF + v);
            b_valid = ~v[1]; b_ready = v[1]; b_chan = 8'(32'h5A + v);
            ar_valid = 1'b1; ar_ready = v[0]; ar_chan = 16'(32'h4242 - v);
            r_valid = v[0] | v[1]; r_ready = 1'b1; r_chan = 16'(32'h0F0F << v);
            #1;
            tests++;
            act_aw = {by_aw_valid_q, by_aw_did_q, by_aw_sid_q, by_aw_chan_q, by_aw_ready_up};
            exp_aw = {v[1], 4'(v + 5), 4'(v), 16'(32'h1234 * (v + 1)), v[0] ^ v[1]};
            if (act_aw !== exp_aw || by_aw_count !== 1'b0) begin
                fails++; $display("FAIL bypass_aw[%0d] got %h exp %h", v, act_aw, exp_aw);
            end
            tests++;
            act_rdy = {by_w_valid_q, by_w_ready_up, by_b_valid_q, by_b_ready_up, by_ar_valid_q, by_ar_ready_up,
                       by_r_valid_q, by_r_ready_up, by_w_count, by_b_count, by_ar_count, by_r_count, 4'd0};
            exp_rdy = {v[0], ~v[0], ~v[1], v[1], 1'b1, v[0], v[0] | v[1], 1'b1, 8'd0};
            if (act_rdy !== exp_rdy) begin
                fails++; $display("FAIL bypass_ctrl[%0d] got %h exp %h", v, act_rdy, exp_rdy);
            end
            tests++;
            act_dat = {by_w_chan_q, by_b_chan_q, by_ar_chan_q[7:0]};
            exp_dat = {16'(32'hBEEF + v), 8'(32'h5A + v), 8'(32'h4242 - v)};
            if (act_dat !== exp_dat || by_r_chan_q !== 16'(32'h0F0F << v)) begin
                fails++; $display("FAIL bypass_data[%0d] got %h/%h exp %h/%h", v, act_dat, by_r_chan_q, exp_dat, 16'(32'h0F0F << v));
            end
            tick();
        end
        flush = 1'b0; arst_n = 1'b1;
        aw_valid = 1'b0; w_valid = 1'b0; b_valid = 1'b0; ar_valid = 1'b0; r_valid = 1'b0;
        tick();
    endtask

    initial begin
        arst_n = 1'b0; flush = 1'b0;
        aw_did = '0; aw_sid = '0; aw_chan = '0; aw_valid = 1'b0; aw_ready = 1'b0;
        w_did = '0; w_sid = '0; w_chan = '0; w_valid = 1'b0; w_ready = 1'b0;
        b_did = '0; b_sid = '0; b_chan = '0; b_valid = 1'b0; b_ready = 1'b0;
        ar_did = '0; ar_sid = '0; ar_chan = '0; ar_valid = 1'b0; ar_ready = 1'b0;
        r_did = '0; r_sid = '0; r_chan = '0; r_valid = 1'b0; r_ready = 1'b0;
        test_reset();
        test_aw_stream();
        test_w_backpressure();
        test_r_depth1();
        test_b_wrap();
        test_flush();
        test_reset_mid();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_grid_link_buffer.md
Name: axi_grid_link_buffer

Overview:
- Parametrised, buffered successor to the grid network-interface pass-through: sits on a grid link between a node and its router.
- Carries all five grid channels: AW, W, B, AR and R.
- Each channel has its own depth-configurable FIFO (depth 0 = combinational bypass), an occupancy output and a shared synchronous flush.
- Registered ready cuts the combinational valid/ready paths across the link.

Parameters:
- grid_id_t, axi_default_param_pkg::grid_id_t, source/destination node ID type.
- grid_aw_chan_t / grid_w_chan_t / grid_b_chan_t / grid_ar_chan_t / grid_r_chan_t, axi_default_param_pkg::grid_<x>_chan_t, payload type per channel.
- AW_DEPTH, 2, AW FIFO entries; 0 = bypass.
- W_DEPTH, 2, W FIFO entries; 0 = bypass.
- B_DEPTH, 2, B FIFO entries; 0 = bypass.
- AR_DEPTH, 2, AR FIFO entries; 0 = bypass.
- R_DEPTH, 2, R FIFO entries; 0 = bypass.

Ports:
- clk_i  input  1  clock.
- arst_ni  input  1  reset, synchronous, active-low.
- flush_i  input  1  synchronous flush of all FIFOs.
- Per channel <x> in {aw, w, b, ar, r}; D = <X>_DEPTH:
  - <x>did_i  input  $bits(grid_id_t)  upstream destination ID.
  - <x>sid_i  input  $bits(grid_id_t)  upstream source ID.
  - <x>chan_i  input  $bits(grid_<x>_chan_t)  upstream payload.
  - <x>valid_i  input  1  upstream valid.
  - <x>ready_o  output  1  upstream ready.
  - <x>did_o  output  $bits(grid_id_t)  downstream destination ID.
  - <x>sid_o  output  $bits(grid_id_t)  downstream source ID.
  - <x>chan_o  output  $bits(grid_<x>_chan_t)  downstream payload.
  - <x>valid_o  output  1  downstream valid.
  - <x>ready_i  input  1  downstream ready.
  - <x>count_o  output  max(1,$clog2(D+1))  current FIFO occupancy.

Behaviour:
- Flit = {did, sid, chan}. push = valid_i & ready_o. pop = valid_o & ready_i. All five channels are fully independent.
- D = 0 (bypass):
  - did/sid/chan/valid_o = inputs; ready_o = ready_i; count_o = 0.
  - flush_i and reset have no effect.
- D >= 1, circular buffer with write pointer, read pointer and count, all registered:
  - Pointers wrap D-1 -> 0, including non-power-of-two D.
  - ready_o = (count != D) & !flush_i & arst_ni. No combinational dependency on ready_i.
  - valid_o = (count != 0) & !flush_i. Output flit = entry at the read pointer.
  - Latency: a flit pushed in cycle n is visible at the outputs in cycle n+1; there is no fall-through.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at any fill level where ready_o = 1.
  - Full (count = D): ready_o = 0; a simultaneous pop does not enable a push that cycle.
  - Empty: valid_o = 0; output flit holds the last-read entry.
  - Throughput: D >= 2 sustains 1 flit/cycle. D = 1 alternates, giving at most 1 flit per 2 cycles under continuous pop.
  - Ordering: strict FIFO per channel; no reordering or dropping except on flush/reset.
  - valid_o, once asserted, holds with a stable flit until pop (AXI-style stability).
- flush_i = 1 in cycle n:
  - valid_o = 0 and ready_o = 0 in cycle n; no push or pop occurs.
  - Counts and pointers are 0 in cycle n+1.
  - Flush held multiple cycles keeps the buffer empty.
- Reset (arst_ni = 0 at a clock edge):
  - Count, pointers and all storage clear to '0; valid_o = 0; did/sid/chan_o = '0; count_o = 0.
  - ready_o = 0 while arst_ni is low; ready_o = 1 in the first cycle after release.
  - Reset mid-traffic discards all stored flits; no partial flit is emitted.
- count_o is exact and registered, in range 0..D.

Test Plan:
- Depth 2, AW, continuous valid, ready_i = 1: push did=3, sid=1 and payloads 0x10..0x17 -> outputs 0x10..0x17 in order, one per cycle, first output 1 cycle after first push, count_o steady at 1.
- Depth 3, W, ready_i = 0: push 4 flits -> ready_o drops after 3rd push, count_o = 3, 4th flit held upstream. Raise ready_i -> all 4 flits delivered in order; the 4th is accepted only after count_o < 3.
- Depth 1, R, ready_i = 1, 6 back-to-back flits -> ready_o toggles, 6 flits delivered in 12 cycles, count_o alternates 1/0.
- Depth 3 (non-power-of-two), B: 10 flits with random ready_i stalls -> pointer wrap correct, no loss or duplication, scoreboard match.
- Flush: AR depth 4 holding 3 flits, flush_i = 1 for 1 cycle -> valid_o = 0 and ready_o = 0 that cycle, count_o = 0 next cycle, the 3 flits never appear.
- Reset mid-traffic: arst_ni = 0 with 2 flits buffered -> count_o = 0 and all outputs '0 next cycle. After release, ready_o = 1 and a new flit arrives 1 cycle after push.
- Bypass: AW_DEPTH = 0 -> outputs equal inputs in the same cycle, ready_o = ready_i, unaffected by flush_i.
